// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: ID-stage sequencer with load-use/multiply stalls, branch flush and forwarding selects
module id_hazard_ctrl #(
    parameter int MUL_LATENCY = 3,
    parameter int REG_ADDR_W  = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic                  rs_used,
    input  logic                  rt_used,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  reg_write,
    input  logic                  is_load,
    input  logic                  is_mul,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  busy
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;
    localparam int CW = $clog2(MUL_LATENCY + 1);

    // The WB slot is not tracked: the write-first register bank makes a WB
    // writer visible to ID directly, so no select ever depends on it.
    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ex_v_q, ex_v_d, ex_wr_q, ex_wr_d, ex_ld_q, ex_ld_d;
    logic [REG_ADDR_W-1:0] ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d;
    logic                  mem_v_q, mem_v_d, mem_wr_q, mem_wr_d;
    logic [1:0]            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic                  run, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic                  load_use, issue, start_mul;

    // Hazard detection, front-end control and next-state computation
    always_comb begin
        run         = state_q == RUN;
        ex_hit_a    = ex_v_q & ex_wr_q & rs_used & (ex_dest_q == rs);
        ex_hit_b    = ex_v_q & ex_wr_q & rt_used & (ex_dest_q == rt);
        mem_hit_a   = mem_v_q & mem_wr_q & rs_used & (mem_dest_q == rs);
        mem_hit_b   = mem_v_q & mem_wr_q & rt_used & (mem_dest_q == rt);
        load_use    = id_valid & ex_ld_q & (ex_hit_a | ex_hit_b);
        pc_write    = run & (branch_taken | ~load_use);
        ifid_write  = run & (branch_taken | ~load_use);
        ifid_flush  = run & branch_taken;
        idex_bubble = run & (branch_taken | load_use);
        busy        = ~run;
        issue       = run & ~branch_taken & ~load_use & id_valid;
        start_mul   = issue & is_mul & (MUL_LATENCY > 1);
        state_d     = run ? (start_mul ? MUL_BUSY : RUN) : (cnt_q == CW'(1) ? RUN : MUL_BUSY);
        cnt_d       = start_mul ? CW'(MUL_LATENCY - 1) : run ? cnt_q : cnt_q - CW'(1);
        ex_v_d      = run ? issue : ex_v_q;
        ex_wr_d     = run ? issue & reg_write : ex_wr_q;
        ex_ld_d     = run ? issue & is_load : ex_ld_q;
        ex_dest_d   = run ? dest : ex_dest_q;
        mem_v_d     = run & ex_v_q;
        mem_wr_d    = ex_wr_q;
        mem_dest_d  = ex_dest_q;
        fwd_a_d     = ~run ? fwd_a_q : ~issue ? 2'b00 : ex_hit_a ? 2'b01 : mem_hit_a ? 2'b10 : 2'b00;
        fwd_b_d     = ~run ? fwd_b_q : ~issue ? 2'b00 : ex_hit_b ? 2'b01 : mem_hit_b ? 2'b10 : 2'b00;
    end

    // State, tag pipeline and forwarding-select registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            ex_v_q     <= 1'b0;
            ex_wr_q    <= 1'b0;
            ex_ld_q    <= 1'b0;
            ex_dest_q  <= '0;
            mem_v_q    <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_dest_q <= '0;
            fwd_a_q    <= 2'b00;
            fwd_b_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ex_v_q     <= ex_v_d;
            ex_wr_q    <= ex_wr_d;
            ex_ld_q    <= ex_ld_d;
            ex_dest_q  <= ex_dest_d;
            mem_v_q    <= mem_v_d;
            mem_wr_q   <= mem_wr_d;
            mem_dest_q <= mem_dest_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: vector table, hand sequences and randomized model check of id_hazard_ctrl
module tb_id_hazard_ctrl;
    localparam int L = 3;

    logic clock = 1'b0, reset_n = 1'b0;
    logic id_valid, rs_used, rt_used, reg_write, is_load, is_mul, branch_taken;
    logic [2:0] rs, rt, dest;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, busy;
    logic [1:0] fwd_a, fwd_b;
    int checks = 0, failures = 0;

    id_hazard_ctrl #(.MUL_LATENCY(L), .REG_ADDR_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .rs(rs), .rt(rt),
        .rs_used(rs_used), .rt_used(rt_used), .dest(dest), .reg_write(reg_write),
        .is_load(is_load), .is_mul(is_mul), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy));

    always #5 clock = ~clock;

    typedef struct {
        logic iv; logic [2:0] rs; logic ru; logic [2:0] rt; logic tu;
        logic [2:0] dest; logic wr; logic ld; logic mul; logic br;
        logic e_pc; logic e_w; logic e_fl; logic e_bub; logic [1:0] e_fa; logic [1:0] e_fb;
    } vec_t;

    typedef struct { logic v; logic [2:0] dest; logic wr; logic ld; } op_t;

    vec_t tbl[10];
    op_t pipe[3];
    int stall_left;
    logic [1:0] efa, efb;

    function automatic vec_t mk(logic iv, logic [2:0] r_s, logic ru, logic [2:0] r_t, logic tu,
                                logic [2:0] d, logic wr, logic ld, logic br,
                                logic e_pc, logic e_w, logic e_fl, logic e_bub,
                                logic [1:0] e_fa, logic [1:0] e_fb);
        vec_t v;
        v = '{iv, r_s, ru, r_t, tu, d, wr, ld, 1'b0, br, e_pc, e_w, e_fl, e_bub, e_fa, e_fb};
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(vec_t v);
        id_valid = v.iv; rs = v.rs; rs_used = v.ru; rt = v.rt; rt_used = v.tu;
        dest = v.dest; reg_write = v.wr; is_load = v.ld; is_mul = v.mul; branch_taken = v.br;
    endtask

    task automatic idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Source select from the spec rules: nearest older writer among EX then MEM
    function automatic logic [1:0] src_sel(logic [2:0] r, logic used);
        if (!used) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (pipe[i].v && pipe[i].wr && pipe[i].dest == r) return 2'(i + 1);
        return 2'b00;
    endfunction

    initial begin
        vec_t v;
        op_t nop;
        logic hz, iss;
        nop = '{1'b0, 3'd0, 1'b0, 1'b0};
        // iv rs ru rt tu dest wr ld br | pc w fl bub fa fb
        tbl[0] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        tbl[1] = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        tbl[2] = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 1, 1, 0, 0, 2, 0);
        tbl[3] = mk(1, 3, 1, 3, 1, 2, 1, 0, 0, 1, 1, 0, 0, 1, 1);
        tbl[4] = mk(1, 3, 1, 2, 1, 2, 1, 0, 0, 1, 1, 0, 0, 2, 1);
        tbl[5] = mk(1, 2, 0, 2, 1, 4, 1, 1, 0, 1, 1, 0, 0, 0, 1);
        tbl[6] = mk(1, 4, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0);
        tbl[7] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        tbl[8] = mk(1, 5, 0, 6, 1, 6, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        tbl[9] = mk(0, 6, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        do_reset();
        #1;
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_bubble", idex_bubble, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(tbl[i]);
            #1;
            chk($sformatf("v%0d_pc_write", i), pc_write, tbl[i].e_pc);
            chk($sformatf("v%0d_ifid_write", i), ifid_write, tbl[i].e_w);
            chk($sformatf("v%0d_flush", i), ifid_flush, tbl[i].e_fl);
            chk($sformatf("v%0d_bubble", i), idex_bubble, tbl[i].e_bub);
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_fwd_a", i), fwd_a, tbl[i].e_fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_b, tbl[i].e_fb);
        end

        // Multiply: front end stalled L-1 cycles, branch ignored, MEM drained to bubbles
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        v = mk(1, 6, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.mul = 1;
        drive(v);
        #1;
        chk("mul_issue_pc", pc_write, 1);
        chk("mul_issue_busy", busy, 0);
        @(negedge clock);
        drive(mk(1, 6, 1, 7, 1, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("mul_t1_busy", busy, 1);
        chk("mul_t1_pc", pc_write, 0);
        chk("mul_t1_ifid_write", ifid_write, 0);
        chk("mul_t1_flush_ignored", ifid_flush, 0);
        chk("mul_t1_bubble", idex_bubble, 0);
        chk("mul_t1_fwd_a_held", fwd_a, 1);
        @(negedge clock);
        branch_taken = 0;
        #1;
        chk("mul_t2_busy", busy, 1);
        chk("mul_t2_pc", pc_write, 0);
        @(negedge clock);
        #1;
        chk("mul_t3_busy", busy, 0);
        chk("mul_t3_pc", pc_write, 1);
        chk("mul_t3_bubble", idex_bubble, 0);
        @(posedge clock);
        #1;
        chk("mul_after_fwd_a_mem_empty", fwd_a, 0);
        chk("mul_after_fwd_b_ex", fwd_b, 1);

        // Reset in the middle of a multiply takes effect without a clock
        do_reset();
        drive(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        v = mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        v.mul = 1;
        drive(v);
        @(negedge clock);
        #1;
        chk("rmul_busy_before", busy, 1);
        chk("rmul_fwd_a_before", fwd_a, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rmul_busy", busy, 0);
        chk("rmul_pc_write", pc_write, 1);
        chk("rmul_fwd_a", fwd_a, 0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rmul_after_pc", pc_write, 1);
        @(posedge clock);
        #1;
        chk("rmul_after_fwd", {fwd_a, fwd_b}, 0);

        // Randomized run against a behavioural model of the in-flight writers
        do_reset();
        for (int i = 0; i < 3; i++) pipe[i] = nop;
        stall_left = 0;
        efa = 0;
        efb = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            v.iv = $urandom_range(0, 7) != 0;
            v.rs = 3'($urandom_range(0, 3));
            v.rt = 3'($urandom_range(0, 3));
            v.ru = $urandom_range(0, 3) != 0;
            v.tu = $urandom_range(0, 1) != 0;
            v.dest = 3'($urandom_range(0, 3));
            v.wr = $urandom_range(0, 4) != 0;
            v.ld = $urandom_range(0, 3) == 0;
            v.mul = !v.ld && $urandom_range(0, 7) == 0;
            v.br = $urandom_range(0, 7) == 0;
            drive(v);
            #1;
            hz = v.iv && pipe[0].v && pipe[0].wr && pipe[0].ld &&
                 ((v.ru && pipe[0].dest == v.rs) || (v.tu && pipe[0].dest == v.rt));
            if (stall_left > 0) begin
                chk("rnd_busy", busy, 1);
                chk("rnd_pc_write", pc_write, 0);
                chk("rnd_ifid_write", ifid_write, 0);
                chk("rnd_flush", ifid_flush, 0);
                chk("rnd_bubble", idex_bubble, 0);
            end else begin
                chk("rnd_busy", busy, 0);
                chk("rnd_pc_write", pc_write, v.br || !hz);
                chk("rnd_ifid_write", ifid_write, v.br || !hz);
                chk("rnd_flush", ifid_flush, v.br);
                chk("rnd_bubble", idex_bubble, v.br || hz);
            end
            chk("rnd_fwd_a", fwd_a, efa);
            chk("rnd_fwd_b", fwd_b, efb);
            @(posedge clock);
            if (stall_left > 0) begin
                pipe[2] = pipe[1];
                pipe[1] = nop;
                stall_left--;
            end else begin
                iss = v.iv && !v.br && !hz;
                efa = iss ? src_sel(v.rs, v.ru) : 2'b00;
                efb = iss ? src_sel(v.rt, v.tu) : 2'b00;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = iss ? '{1'b1, v.dest, v.wr, v.ld} : nop;
                if (iss && v.mul) stall_left = L - 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
